// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous byte FIFO.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

  // Every bit of Q takes this value while reset is active.
  localparam logic Q_RST_BIT = 1'b0;

  // Pointer width: address bits plus one wrap bit that separates full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int ENTRIES = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [ENTRIES];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array; contents are not reset because stale entries are never read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read data only changes on an accepted read; otherwise it holds the last value.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= {DATA_WIDTH{Q_RST_BIT}};
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_top.sv
// Single-clock synchronous FIFO with registered flags, occupancy count and read data.
module fifo_top
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     WrEn,
  input  logic [DATA_WIDTH-1:0]    Data,
  input  logic                     RdEn,
  output logic [DATA_WIDTH-1:0]    Q,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Wnum
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [1:0]    rst_sync_q;
  logic          rst_n_s;
  logic          wr_acc_s;
  logic          rd_acc_s;
  logic [PW-1:0] wptr_d, wptr_q;
  logic [PW-1:0] rptr_d, rptr_q;
  logic          full_d, full_q;
  logic          empty_d, empty_q;
  logic [PW-1:0] wnum_d, wnum_q;

  // Reset asserts immediately and releases after two clock edges.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_q[1];

  // Flags are registered, so the gates use only state and never create an input-to-output path.
  assign wr_acc_s = WrEn && !full_q;
  assign rd_acc_s = RdEn && !empty_q;

  // Next pointers, and flags and count derived from those next pointers.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (wr_acc_s) begin
      wptr_d = wptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_acc_s) begin
      rptr_d = rptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rptr_d = rptr_q;
    end
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    wnum_d  = wptr_d - rptr_d;
  end

  // Pointer, flag and count registers.
  always_ff @(posedge Clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      wnum_q  <= {PW{1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      wnum_q  <= wnum_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk_i   (Clk),
    .rst_n_i (rst_n_s),
    .we_i    (wr_acc_s),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (Data),
    .re_i    (rd_acc_s),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (Q)
  );

  assign Full  = full_q;
  assign Empty = empty_q;
  assign Wnum  = wnum_q;

endmodule

// File: tb/tb_fifo_top.sv
// Directed testbench for fifo_top with hand-computed expected values.
module tb_fifo_top;

  logic       Clk;
  logic       Reset;
  logic       WrEn;
  logic [7:0] Data;
  logic       RdEn;
  logic [7:0] Q;
  logic       Full;
  logic       Empty;
  logic [4:0] Wnum;

  int checks;
  int failures;

  fifo_top #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .WrEn  (WrEn),
    .Data  (Data),
    .RdEn  (RdEn),
    .Q     (Q),
    .Full  (Full),
    .Empty (Empty),
    .Wnum  (Wnum)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, then settle.
  task automatic cyc(input logic we, input logic [7:0] d, input logic re);
    @(negedge Clk);
    WrEn = we;
    Data = d;
    RdEn = re;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] q, input logic f,
                           input logic e, input logic [4:0] n);
    chk({tag, ".Q"},     {24'd0, Q},     {24'd0, q});
    chk({tag, ".Full"},  {31'd0, Full},  {31'd0, f});
    chk({tag, ".Empty"}, {31'd0, Empty}, {31'd0, e});
    chk({tag, ".Wnum"},  {27'd0, Wnum},  {27'd0, n});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset = 1'b0;
    WrEn  = 1'b0;
    Data  = 8'h00;
    RdEn  = 1'b0;

    // Reset and idle.
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    chk_state("in_reset", 8'h00, 1'b0, 1'b1, 5'd0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    chk_state("idle", 8'h00, 1'b0, 1'b1, 5'd0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk_state("rd_empty", 8'h00, 1'b0, 1'b1, 5'd0);

    // Three writes then three reads.
    cyc(1'b1, 8'h65, 1'b0);
    chk_state("wr1", 8'h00, 1'b0, 1'b0, 5'd1);
    cyc(1'b1, 8'h66, 1'b0);
    cyc(1'b1, 8'h67, 1'b0);
    chk("wr3.Wnum", {27'd0, Wnum}, 32'd3);
    cyc(1'b0, 8'h00, 1'b1);
    chk_state("rd1", 8'h65, 1'b0, 1'b0, 5'd2);
    cyc(1'b0, 8'h00, 1'b1);
    chk("rd2.Q", {24'd0, Q}, 32'h66);
    cyc(1'b0, 8'h00, 1'b1);
    chk_state("rd3", 8'h67, 1'b0, 1'b1, 5'd0);

    // Fill to full, drop a 17th write, drain.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == 14) chk("fill15.Full", {31'd0, Full}, 32'd0);
    end
    chk_state("full", 8'h67, 1'b1, 1'b0, 5'd16);
    cyc(1'b1, 8'hAA, 1'b0);
    chk_state("wr_full", 8'h67, 1'b1, 1'b0, 5'd16);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk($sformatf("drain%0d.Q", i), {24'd0, Q}, 32'(i));
      if (i == 0) chk("drain0.Full", {31'd0, Full}, 32'd0);
    end
    chk_state("drained", 8'h0F, 1'b0, 1'b1, 5'd0);
    cyc(1'b0, 8'h00, 1'b1);
    chk_state("drained_rd", 8'h0F, 1'b0, 1'b1, 5'd0);

    // Five entries, then 20 simultaneous read+write edges across pointer wrap.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
    chk("five.Wnum", {27'd0, Wnum}, 32'd5);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'(8'h85 + i), 1'b1);
      chk($sformatf("rw%0d.Q", i), {24'd0, Q}, 32'(8'h80 + i));
      chk($sformatf("rw%0d.Wnum", i), {27'd0, Wnum}, 32'd5);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk($sformatf("rwdrain%0d.Q", i), {24'd0, Q}, 32'(8'h94 + i));
    end
    chk_state("rw_done", 8'h98, 1'b0, 1'b1, 5'd0);

    // Full with both requested: only the read happens.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    chk("refill.Full", {31'd0, Full}, 32'd1);
    cyc(1'b1, 8'hEE, 1'b1);
    chk_state("full_rw", 8'h40, 1'b0, 1'b0, 5'd15);
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk($sformatf("fdrain%0d.Q", i), {24'd0, Q}, 32'(8'h40 + i));
    end
    chk("fdrain.Empty", {31'd0, Empty}, 32'd1);

    // Empty with both requested: only the write happens, Q holds.
    cyc(1'b1, 8'h5A, 1'b1);
    chk_state("empty_rw", 8'h4F, 1'b0, 1'b0, 5'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk_state("empty_rw_rd", 8'h5A, 1'b0, 1'b1, 5'd0);

    // Seven entries with Q loaded, then asynchronous reset mid-burst.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk_state("pre_rst", 8'h10, 1'b0, 1'b0, 5'd7);
    @(negedge Clk);
    WrEn = 1'b1;
    Data = 8'h77;
    #2;
    Reset = 1'b0;
    #1;
    chk_state("async_rst", 8'h00, 1'b0, 1'b1, 5'd0);
    cyc(1'b1, 8'h78, 1'b0);
    chk_state("held_rst", 8'h00, 1'b0, 1'b1, 5'd0);
    @(negedge Clk);
    Reset = 1'b1;
    WrEn  = 1'b0;
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    chk_state("post_rst", 8'h00, 1'b0, 1'b1, 5'd0);
    cyc(1'b1, 8'h31, 1'b0);
    chk("post_wr.Wnum", {27'd0, Wnum}, 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk_state("post_rd", 8'h31, 1'b0, 1'b1, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
